tt_um_example: RTL and testbench

TT_UM_EXAMPLE -- requirements
Module: tt_um_example

---
 rtl/tt_um_example.sv | 114 +++++++++++
 tb/tb_tt_um_example.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_example.sv
// Up/down counter with programmable wrap limit; 1-cycle step latency; no backpressure, ena=0 freezes all state.
// Define COUNTER_STICKY_WRAP_EN to build the sticky wrap flag on uio_out[6]; otherwise that bit is tied low.
module tt_um_example (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst
);

    logic load;
    logic cnt_en;
    logic up;
    logic load_limit;
    logic clr;

    assign load       = uio_in[0];
    assign cnt_en     = uio_in[1];
    assign up         = uio_in[2];
    assign load_limit = uio_in[3];
    assign clr        = uio_in[4];

    logic unused_uio_in;
    assign unused_uio_in = &{1'b0, uio_in[7:5]};

    logic [7:0] count_q, count_d;
    logic [7:0] limit_q, limit_d;
    logic       wrap_pulse_q, wrap_pulse_d;
    logic       step_wrap;
    logic       sticky_wrap;

    // Count actions compare against limit_q, so a limit written this cycle only takes effect next cycle.
    always_comb begin
        count_d      = count_q;
        limit_d      = limit_q;
        wrap_pulse_d = wrap_pulse_q;
        step_wrap    = 1'b0;
        if (ena) begin
            if (load_limit) begin
                limit_d = ui_in;
            end
            if (clr) begin
                count_d = '0;
            end else if (load) begin
                count_d = ui_in;
            end else if (cnt_en) begin
                if (up) begin
                    if (count_q >= limit_q) begin
                        count_d   = '0;
                        step_wrap = 1'b1;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end else begin
                    if (count_q == 8'd0) begin
                        count_d   = limit_q;
                        step_wrap = 1'b1;
                    end else begin
                        count_d = count_q - 8'd1;
                    end
                end
            end
            wrap_pulse_d = step_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            limit_q      <= 8'hFF;
            wrap_pulse_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            limit_q      <= limit_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

`ifdef COUNTER_STICKY_WRAP_EN
    logic sticky_wrap_q, sticky_wrap_d;

    // clr beats a coincident wrap; a step never happens alongside clr anyway.
    always_comb begin
        sticky_wrap_d = sticky_wrap_q;
        if (ena) begin
            if (clr) begin
                sticky_wrap_d = 1'b0;
            end else if (step_wrap) begin
                sticky_wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_wrap_q <= 1'b0;
        end else begin
            sticky_wrap_q <= sticky_wrap_d;
        end
    end

    assign sticky_wrap = sticky_wrap_q;
`else
    assign sticky_wrap = 1'b0;
`endif

    assign uo_out  = count_q;
    assign uio_out = {(count_q == limit_q), sticky_wrap, (count_q == 8'd0), wrap_pulse_q, 4'b0000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_example.sv
// Directed bench for tt_um_example: a per-cycle reference model plus hand-computed literal checks.
module tb_tt_um_example;

`ifdef COUNTER_STICKY_WRAP_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_example dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst    (rst)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain integer state updated from the behavioural rules.
    int m_count  = 0;
    int m_limit  = 255;
    bit m_wrap   = 1'b0;
    bit m_sticky = 1'b0;
    bit m_valid  = 1'b0;

    always @(posedge clk) begin
        int  nc;
        bit  w;
        if (rst) begin
            m_count  = 0;
            m_limit  = 255;
            m_wrap   = 1'b0;
            m_sticky = 1'b0;
            m_valid  = 1'b1;
        end else if (ena) begin
            nc = m_count;
            w  = 1'b0;
            if (uio_in[4]) nc = 0;
            else if (uio_in[0]) nc = int'(ui_in);
            else if (uio_in[1]) begin
                if (uio_in[2]) begin
                    if (m_count >= m_limit) begin nc = 0; w = 1'b1; end
                    else nc = (m_count + 1) % 256;
                end else begin
                    if (m_count == 0) begin nc = m_limit; w = 1'b1; end
                    else nc = m_count - 1;
                end
            end
            if (uio_in[3]) m_limit = int'(ui_in);
            m_count = nc;
            m_wrap  = w;
            if (uio_in[4]) m_sticky = 1'b0;
            else if (w && STICKY) m_sticky = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_uio;
        if (m_valid) begin
            exp_uio = {(m_count == m_limit), m_sticky, (m_count == 0), m_wrap, 4'b0000};
            total++;
            if (uo_out !== 8'(m_count)) begin
                bad++;
                $display("FAIL model_uo_out t=%0t actual=%02h required=%02h", $time, uo_out, 8'(m_count));
            end
            total++;
            if (uio_out !== exp_uio) begin
                bad++;
                $display("FAIL model_uio_out t=%0t actual=%02h required=%02h", $time, uio_out, exp_uio);
            end
            total++;
            if (uio_oe !== 8'hE0) begin
                bad++;
                $display("FAIL model_uio_oe t=%0t actual=%02h required=e0", $time, uio_oe);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    // Bits [7:5] carry junk to show they are ignored.
    task automatic ctrl(input bit ld, input bit ce, input bit u, input bit ll, input bit cl);
        uio_in = {3'b101, cl, ll, u, ce, ld};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq [6];
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};

        ena = 1'b1;
        rst = 1'b1;
        ctrl(1, 1, 1, 1, 0);
        ui_in = 8'h77;
        cyc();
        rst = 1'b0;
        ctrl(0, 0, 0, 0, 0);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h20);
        chk("reset_uio_oe", uio_oe, 8'hE0);

        ctrl(0, 1, 1, 0, 0);
        cyc();
        chk("up_1", uo_out, 8'h01);
        chk("up_1_zero", {7'b0, uio_out[5]}, 8'h00);
        cyc();
        chk("up_2", uo_out, 8'h02);
        cyc();
        chk("up_3", uo_out, 8'h03);

        ui_in = 8'hFE;
        ctrl(1, 0, 0, 0, 0);
        cyc();
        chk("load_fe", uo_out, 8'hFE);
        ctrl(0, 1, 1, 0, 0);
        cyc();
        chk("up_ff", uo_out, 8'hFF);
        chk("up_ff_at_limit", {7'b0, uio_out[7]}, 8'h01);
        cyc();
        chk("wrap_to_00", uo_out, 8'h00);
        chk("wrap_pulse_hi", {7'b0, uio_out[4]}, 8'h01);
        chk("sticky_set", {7'b0, uio_out[6]}, {7'b0, STICKY});
        ctrl(0, 0, 0, 0, 0);
        cyc();
        chk("wrap_pulse_lo", {7'b0, uio_out[4]}, 8'h00);

        ui_in = 8'h05;
        ctrl(0, 0, 0, 1, 1);
        cyc();
        chk("clr_sticky", {7'b0, uio_out[6]}, 8'h00);
        ctrl(0, 1, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("lim5_up_%0d", i), uo_out, seq[i]);
            if (i == 4) chk("lim5_at_limit", {7'b0, uio_out[7]}, 8'h01);
        end

        ctrl(0, 1, 0, 0, 0);
        cyc();
        chk("down_wrap_5", uo_out, 8'h05);
        chk("down_wrap_pulse", {7'b0, uio_out[4]}, 8'h01);
        cyc();
        chk("down_4", uo_out, 8'h04);
        chk("down_pulse_once", {7'b0, uio_out[4]}, 8'h00);

        ui_in = 8'h02;
        ctrl(0, 1, 1, 1, 0);
        cyc();
        chk("old_limit_used", uo_out, 8'h05);
        ctrl(0, 1, 1, 0, 0);
        cyc();
        chk("new_limit_wraps", uo_out, 8'h00);

        ui_in = 8'h10;
        ctrl(1, 0, 0, 0, 0);
        cyc();
        ctrl(0, 1, 0, 0, 0);
        cyc();
        chk("above_limit_down", uo_out, 8'h0F);
        ctrl(0, 1, 1, 0, 0);
        cyc();
        chk("above_limit_up_wrap", uo_out, 8'h00);

        ui_in = 8'h33;
        ctrl(1, 0, 0, 0, 1);
        cyc();
        chk("clr_beats_load", uo_out, 8'h00);
        ctrl(0, 1, 0, 0, 0);
        cyc();
        chk("resticky", {7'b0, uio_out[6]}, {7'b0, STICKY});
        ctrl(0, 0, 0, 0, 1);
        cyc();
        chk("clr_alone_sticky", {7'b0, uio_out[6]}, 8'h00);

        ui_in = 8'h00;
        ctrl(0, 0, 0, 1, 0);
        cyc();
        ctrl(0, 1, 1, 0, 0);
        cyc();
        chk("lim0_up", uo_out, 8'h00);
        chk("lim0_up_wrap", {7'b0, uio_out[4]}, 8'h01);
        ctrl(0, 1, 0, 0, 0);
        cyc();
        chk("lim0_down", uo_out, 8'h00);
        chk("lim0_down_wrap", {7'b0, uio_out[4]}, 8'h01);
        ctrl(0, 1, 1, 0, 1);
        cyc();
        chk("clr_vs_wrap", uio_out, 8'hA0);

        ui_in = 8'hFF;
        ctrl(0, 0, 0, 1, 0);
        cyc();
        ui_in = 8'h42;
        ctrl(1, 0, 0, 0, 0);
        cyc();
        ena = 1'b0;
        ui_in = 8'h99;
        ctrl(1, 1, 1, 1, 0);
        cyc();
        chk("ena0_hold", uo_out, 8'h42);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("ena0_rst_count", uo_out, 8'h00);
        chk("ena0_rst_flags", uio_out, 8'h20);
        ena = 1'b1;
        ctrl(0, 0, 0, 0, 0);
        ui_in = 8'hFF;
        ctrl(1, 0, 0, 0, 0);
        cyc();
        chk("rst_limit_ff", {7'b0, uio_out[7]}, 8'h01);

        ctrl(0, 1, 1, 0, 0);
        ui_in = 8'h00;
        ctrl(1, 0, 0, 0, 0);
        cyc();
        ctrl(0, 1, 1, 0, 0);
        cyc();
        cyc();
        ui_in = 8'h07;
        ctrl(1, 1, 1, 1, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ctrl(0, 0, 0, 0, 0);
        chk("rst_mid_count", uo_out, 8'h00);
        chk("rst_ignores_loads", uio_out, 8'h20);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
